switch_xbar_scheduler: RTL and testbench



---
 rtl/switch_xbar_pkg.sv | 27 ++
 rtl/switch_xbar_alloc.sv | 40 ++++
 rtl/switch_xbar_scheduler.sv | 112 +++++++++++
 tb/tb_switch_xbar_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_xbar_pkg.sv
// Shared types for the crossbar scheduler: FSM states, port masks/indices,
// and the round-robin scan helper used by both allocator and top.
package switch_xbar_pkg;

   localparam int NUM_PORTS_C = 4;
   localparam int PORT_IDX_W  = 2;

   typedef logic [NUM_PORTS_C-1:0] port_mask_t;
   typedef logic [PORT_IDX_W-1:0]  port_idx_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALLOC,
      S_DELIVER
   } sched_state_e;

   // First set bit of vec scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); ptr if none.
   function automatic port_idx_t first_in_scan(input port_idx_t ptr, input port_mask_t vec);
      port_idx_t idx;
      first_in_scan = ptr;
      for (int k = NUM_PORTS_C; k >= 1; k--) begin
         idx = ptr + port_idx_t'(k);
         if (vec[idx]) first_in_scan = idx;
      end
   endfunction

endpackage

// File: rtl/switch_xbar_alloc.sv
// Combinational all-or-nothing output allocation in round-robin scan order.
// Zero latency; no backpressure (pure function of req/target/pointer).
module switch_xbar_alloc
   import switch_xbar_pkg::*;
(
   input  logic [NUM_PORTS_C-1:0]                   req_i,
   input  logic [NUM_PORTS_C-1:0][NUM_PORTS_C-1:0]  req_target_i,
   input  logic [PORT_IDX_W-1:0]                    rr_ptr_i,
   output logic [NUM_PORTS_C-1:0]                   win_o,
   output logic [NUM_PORTS_C-1:0]                   load_o,
   output logic [NUM_PORTS_C-1:0][PORT_IDX_W-1:0]   src_o,
   output logic [NUM_PORTS_C-1:0]                   zero_o
);

   always_comb begin
      port_mask_t taken;
      port_idx_t  idx;
      taken  = '0;
      idx    = '0;
      win_o  = '0;
      zero_o = '0;
      src_o  = '0;
      for (int k = 1; k <= NUM_PORTS_C; k++) begin
         idx = rr_ptr_i + port_idx_t'(k);
         if (req_i[idx]) begin
            if (req_target_i[idx] == '0) begin
               zero_o[idx] = 1'b1;
            end else if ((req_target_i[idx] & taken) == '0) begin
               win_o[idx] = 1'b1;
               for (int o = 0; o < NUM_PORTS_C; o++) begin
                  if (req_target_i[idx][o]) src_o[o] = idx;
               end
               taken = taken | req_target_i[idx];
            end
         end
      end
      load_o = taken;
   end

endmodule

// File: rtl/switch_xbar_scheduler.sv
// 4-port crossbar scheduler: IDLE -> ALLOC -> DELIVER rounds, grant/out_valid two cycles after req.
// Outputs hold until their out_ready; a watchdog drops stalled deliveries after TIMEOUT cycles.
module switch_xbar_scheduler
   import switch_xbar_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_PORTS-1:0]                   req_i,
   input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    req_target_i,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]       req_data_i,
   output logic [NUM_PORTS-1:0]                   grant_o,
   output logic [NUM_PORTS-1:0]                   out_valid_o,
   output logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]   out_src_o,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]       out_data_o,
   input  logic [NUM_PORTS-1:0]                   out_ready_i,
   output logic                                   busy_o,
   output logic                                   drop_pulse_o,
   output logic [PORT_IDX_W-1:0]                  rr_ptr_o
);

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   sched_state_e                          state_q;
   logic [NUM_PORTS-1:0]                  grant_q;
   logic [NUM_PORTS-1:0]                  out_valid_q;
   logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  out_src_q;
   logic [NUM_PORTS-1:0][DATA_W-1:0]      out_data_q;
   logic                                  drop_q;
   logic [PORT_IDX_W-1:0]                 rr_ptr_q;
   logic [7:0]                            wd_q;

   logic [NUM_PORTS-1:0]                  win, load, zero, valid_d;
   logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  src;

   switch_xbar_alloc u_alloc (
      .req_i        (req_i),
      .req_target_i (req_target_i),
      .rr_ptr_i     (rr_ptr_q),
      .win_o        (win),
      .load_o       (load),
      .src_o        (src),
      .zero_o       (zero)
   );

   assign valid_d = out_valid_q & ~out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         out_valid_q <= '0;
         out_src_q   <= '0;
         out_data_q  <= '0;
         drop_q      <= 1'b0;
         rr_ptr_q    <= 2'd3;
         wd_q        <= '0;
      end else begin
         grant_q <= '0;
         drop_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               wd_q <= '0;
               if (|req_i) state_q <= S_ALLOC;
            end
            S_ALLOC: begin
               grant_q     <= win | zero;
               drop_q      <= |zero;
               out_valid_q <= load;
               for (int o = 0; o < NUM_PORTS; o++) begin
                  if (load[o]) begin
                     out_src_q[o]  <= src[o];
                     out_data_q[o] <= req_data_i[src[o]];
                  end
               end
               if (|win) rr_ptr_q <= first_in_scan(rr_ptr_q, win);
               wd_q    <= '0;
               state_q <= (|load) ? S_DELIVER : S_IDLE;
            end
            S_DELIVER: begin
               // Completion wins over timeout when the last output is accepted on the final cycle.
               if (valid_d == '0) begin
                  out_valid_q <= '0;
                  wd_q        <= '0;
                  state_q     <= S_IDLE;
               end else if (wd_q == WD_LAST) begin
                  out_valid_q <= '0;
                  drop_q      <= 1'b1;
                  wd_q        <= '0;
                  state_q     <= S_IDLE;
               end else begin
                  out_valid_q <= valid_d;
                  wd_q        <= wd_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign out_valid_o  = out_valid_q;
   assign out_src_o    = out_src_q;
   assign out_data_o   = out_data_q;
   assign busy_o       = (state_q != S_IDLE);
   assign drop_pulse_o = drop_q;
   assign rr_ptr_o     = rr_ptr_q;

endmodule

// File: tb/tb_switch_xbar_scheduler.sv
// Directed bench for switch_xbar_scheduler: cycle table plus multi-cycle corner sequences.
module tb_switch_xbar_scheduler;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req, grant, out_valid, out_ready;
   logic [3:0][3:0]  req_target;
   logic [3:0][15:0] req_data, out_data, dtab;
   logic [3:0][1:0]  out_src;
   logic             busy, drop_pulse;
   logic [1:0]       rr_ptr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] tgt;
      logic [3:0]  g;
      logic [3:0]  v;
      logic        b;
      logic [1:0]  p;
      logic        ce;
      logic [1:0]  co;
      logic [1:0]  src;
   } vec_t;

   vec_t tbl[18];

   switch_xbar_scheduler #(.NUM_PORTS(4), .DATA_W(16), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .req_target_i (req_target),
      .req_data_i   (req_data),
      .grant_o      (grant),
      .out_valid_o  (out_valid),
      .out_src_o    (out_src),
      .out_data_o   (out_data),
      .out_ready_i  (out_ready),
      .busy_o       (busy),
      .drop_pulse_o (drop_pulse),
      .rr_ptr_o     (rr_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] rq, input logic [15:0] tg, input logic [3:0] g,
                               input logic [3:0] v, input logic b, input logic [1:0] p,
                               input logic ce, input logic [1:0] co, input logic [1:0] s);
      vec_t r;
      r.req = rq; r.tgt = tg; r.g = g; r.v = v; r.b = b; r.p = p;
      r.ce = ce; r.co = co; r.src = s;
      return r;
   endfunction

   task automatic chk_idle_reset(input string tag);
      chk({tag, " grant"}, 32'(grant), 32'h0);
      chk({tag, " valid"}, 32'(out_valid), 32'h0);
      chk({tag, " src"}, 32'(out_src), 32'h0);
      chk({tag, " data"}, 32'(out_data != '0), 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
      chk({tag, " drop"}, 32'(drop_pulse), 32'h0);
      chk({tag, " ptr"}, 32'(rr_ptr), 32'h3);
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      req_target = '0;
      dtab       = {16'h3333, 16'h2222, 16'hA5A5, 16'h1111};
      req_data   = dtab;
      out_ready  = 4'hF;

      // Four-way contention on output 0 from reset, then a unicast 1 -> 2.
      tbl[0]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
      tbl[1]  = mk(4'hF, 16'h1111, 4'h1, 4'h1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0);
      tbl[2]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0);
      tbl[3]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0);
      tbl[4]  = mk(4'hF, 16'h1111, 4'h2, 4'h1, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1);
      tbl[5]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1, 2'd0, 2'd1);
      tbl[6]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0);
      tbl[7]  = mk(4'hF, 16'h1111, 4'h4, 4'h1, 1'b1, 2'd2, 1'b1, 2'd0, 2'd2);
      tbl[8]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b0, 2'd2, 1'b1, 2'd0, 2'd2);
      tbl[9]  = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0);
      tbl[10] = mk(4'hF, 16'h1111, 4'h8, 4'h1, 1'b1, 2'd3, 1'b1, 2'd0, 2'd3);
      tbl[11] = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b0, 2'd3, 1'b1, 2'd0, 2'd3);
      tbl[12] = mk(4'hF, 16'h1111, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
      tbl[13] = mk(4'hF, 16'h1111, 4'h1, 4'h1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0);
      tbl[14] = mk(4'h0, 16'h1111, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0);
      tbl[15] = mk(4'h2, 16'h0040, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0);
      tbl[16] = mk(4'h2, 16'h0040, 4'h2, 4'h4, 1'b1, 2'd1, 1'b1, 2'd2, 2'd1);
      tbl[17] = mk(4'h0, 16'h0040, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1, 2'd2, 2'd1);

      step();
      chk_idle_reset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         req        = tbl[i].req;
         req_target = tbl[i].tgt;
         step();
         chk($sformatf("tbl%0d grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].b));
         chk($sformatf("tbl%0d drop", i), 32'(drop_pulse), 32'h0);
         chk($sformatf("tbl%0d ptr", i), 32'(rr_ptr), 32'(tbl[i].p));
         if (tbl[i].ce) begin
            chk($sformatf("tbl%0d src", i), 32'(out_src[tbl[i].co]), 32'(tbl[i].src));
            chk($sformatf("tbl%0d data", i), 32'(out_data[tbl[i].co]), 32'(dtab[tbl[i].src]));
         end
      end

      // Multicast blocking: input 0 takes {0,1}, input 1 wanting 1 waits a round.
      rst_n = 1'b0;
      step();
      rst_n      = 1'b1;
      req_target = 16'h0023;
      req        = 4'b0011;
      step();
      chk("mc alloc busy", 32'(busy), 32'h1);
      step();
      chk("mc r1 grant", 32'(grant), 32'h1);
      chk("mc r1 valid", 32'(out_valid), 32'h3);
      chk("mc r1 src1", 32'(out_src[1]), 32'h0);
      chk("mc r1 ptr", 32'(rr_ptr), 32'h0);
      req = 4'b0010;
      step();
      chk("mc r1 done", 32'(busy), 32'h0);
      step();
      chk("mc r2 alloc", 32'(busy), 32'h1);
      step();
      chk("mc r2 grant", 32'(grant), 32'h2);
      chk("mc r2 valid", 32'(out_valid), 32'h2);
      chk("mc r2 src1", 32'(out_src[1]), 32'h1);
      chk("mc r2 data1", 32'(out_data[1]), 32'hA5A5);
      chk("mc r2 ptr", 32'(rr_ptr), 32'h1);
      req = 4'b0000;
      step();
      chk("mc idle", 32'(busy), 32'h0);

      // Backpressure: input 3 multicasts to {2,3}; output 3 stalls five cycles.
      req_target = 16'hC000;
      req        = 4'b1000;
      out_ready  = 4'b0111;
      step();
      step();
      chk("bp grant", 32'(grant), 32'h8);
      chk("bp valid", 32'(out_valid), 32'hC);
      chk("bp src2", 32'(out_src[2]), 32'h3);
      chk("bp ptr", 32'(rr_ptr), 32'h3);
      req = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("bp stall%0d valid", k), 32'(out_valid), 32'h8);
         chk($sformatf("bp stall%0d busy", k), 32'(busy), 32'h1);
         chk($sformatf("bp stall%0d data3", k), 32'(out_data[3]), 32'h3333);
         chk($sformatf("bp stall%0d src3", k), 32'(out_src[3]), 32'h3);
      end
      out_ready = 4'hF;
      step();
      chk("bp done valid", 32'(out_valid), 32'h0);
      chk("bp done busy", 32'(busy), 32'h0);
      chk("bp done drop", 32'(drop_pulse), 32'h0);

      // Watchdog: output 0 never ready, dropped after eight DELIVER cycles.
      req_target = 16'h0001;
      req        = 4'b0001;
      out_ready  = 4'h0;
      step();
      step();
      chk("wd grant", 32'(grant), 32'h1);
      chk("wd valid", 32'(out_valid), 32'h1);
      chk("wd ptr", 32'(rr_ptr), 32'h0);
      req = 4'b0000;
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("wd hold%0d valid", k), 32'(out_valid), 32'h1);
         chk($sformatf("wd hold%0d drop", k), 32'(drop_pulse), 32'h0);
      end
      step();
      chk("wd drop", 32'(drop_pulse), 32'h1);
      chk("wd drop valid", 32'(out_valid), 32'h0);
      chk("wd drop busy", 32'(busy), 32'h0);
      step();
      chk("wd drop one-shot", 32'(drop_pulse), 32'h0);

      // Zero-mask request: grant and drop, nothing loaded.
      req_target = 16'h0000;
      req        = 4'b0100;
      out_ready  = 4'hF;
      step();
      chk("zm alloc busy", 32'(busy), 32'h1);
      step();
      chk("zm grant", 32'(grant), 32'h4);
      chk("zm drop", 32'(drop_pulse), 32'h1);
      chk("zm valid", 32'(out_valid), 32'h0);
      chk("zm busy", 32'(busy), 32'h0);
      chk("zm ptr", 32'(rr_ptr), 32'h0);
      req = 4'b0000;
      step();
      chk("zm grant clr", 32'(grant), 32'h0);
      chk("zm drop clr", 32'(drop_pulse), 32'h0);

      // Asynchronous reset while outputs 0 and 2 are pending.
      req_target = 16'h0401;
      req        = 4'b0101;
      out_ready  = 4'h0;
      step();
      step();
      chk("rst pre valid", 32'(out_valid), 32'h5);
      chk("rst pre grant", 32'(grant), 32'h5);
      chk("rst pre ptr", 32'(rr_ptr), 32'h2);
      req   = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk_idle_reset("async rst");
      step();
      rst_n = 1'b1;
      step();
      chk("post rst valid", 32'(out_valid), 32'h0);
      chk("post rst busy", 32'(busy), 32'h0);
      chk("post rst ptr", 32'(rr_ptr), 32'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
